// File: rtl/sync_pkg.sv
// sync_pkg: shared definitions for the sync_filter input conditioner.
//   cnt_width(filt_cyc) : width of a per-channel stability counter
//   SYNC_STAGES_DEF     : default synchronizer depth
//   FILT_CYC_DEF        : default stability window, in cycles
//   edge_t              : rise/fall pulse pair for downstream consumers
package sync_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int FILT_CYC_DEF    = 3;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_t;

   function automatic int cnt_width(input int filt_cyc);
      return $clog2(filt_cyc + 1);
   endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// sync_filter_chan: one channel of the input conditioner.
// An asynchronous pin is passed through a STAGES-deep synchronizer chain,
// then through a stability filter that only accepts a new level after it
// has been held for FILT_CYC consecutive cycles. A registered one-cycle
// rise or fall pulse accompanies each accepted change.
//   clk      in   system clock
//   n_rst    in   synchronous active-low reset
//   async_in in   asynchronous pin
//   sync_raw out  last synchronizer stage, unfiltered
//   sync_out out  filtered level
//   rise     out  one-cycle pulse on sync_out 0->1
//   fall     out  one-cycle pulse on sync_out 1->0
module sync_filter_chan
   import sync_pkg::*;
#(
   parameter int   STAGES   = SYNC_STAGES_DEF,
   parameter int   FILT_CYC = FILT_CYC_DEF,
   parameter logic RST_VAL  = 1'b1
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_raw,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   localparam int            CW       = cnt_width(FILT_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

   generate
      if (STAGES < 2) begin : g_bad_stages
         $error("sync_filter_chan: STAGES must be at least 2");
      end
      if (FILT_CYC < 1) begin : g_bad_filt
         $error("sync_filter_chan: FILT_CYC must be at least 1");
      end
   endgenerate

   logic [STAGES-1:0] chain;
   logic [CW-1:0]     cnt;
   logic              mismatch;
   logic              commit;

   assign sync_raw = chain[STAGES-1];
   assign mismatch = chain[STAGES-1] ^ sync_out;
   // Commit on the FILT_CYC-th consecutive mismatching edge.
   assign commit   = mismatch && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         chain    <= {STAGES{RST_VAL}};
         sync_out <= RST_VAL;
         cnt      <= '0;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         // Pulses land in the same cycle the new sync_out becomes visible.
         rise  <= commit & chain[STAGES-1];
         fall  <= commit & ~chain[STAGES-1];
         if (!mismatch) begin
            cnt <= '0;
         end else if (commit) begin
            sync_out <= chain[STAGES-1];
            cnt      <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sync_filter.sv
// sync_filter: multi-channel synchronizer and glitch filter for
// asynchronous boundary pins (USB D+/D-, external strobes). Each channel
// is independent and resets to its own bit of RST_VAL.
//   clk      in   system clock
//   n_rst    in   synchronous active-low reset
//   async_in in   [WIDTH] asynchronous pins
//   sync_raw out  [WIDTH] synchronized, unfiltered levels
//   sync_out out  [WIDTH] synchronized, filtered levels
//   rise     out  [WIDTH] one-cycle pulse on sync_out 0->1
//   fall     out  [WIDTH] one-cycle pulse on sync_out 1->0
module sync_filter
   import sync_pkg::*;
#(
   parameter int               WIDTH    = 2,
   parameter int               STAGES   = SYNC_STAGES_DEF,
   parameter int               FILT_CYC = FILT_CYC_DEF,
   parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_raw,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("sync_filter: WIDTH must be at least 1");
      end
   endgenerate

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_chan
         sync_filter_chan #(
            .STAGES   (STAGES),
            .FILT_CYC (FILT_CYC),
            .RST_VAL  (RST_VAL[i])
         ) u_chan (
            .clk      (clk),
            .n_rst    (n_rst),
            .async_in (async_in[i]),
            .sync_raw (sync_raw[i]),
            .sync_out (sync_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_sync_filter.sv
module tb_sync_filter;

   localparam int         STG = 2;
   localparam logic [1:0] RV  = 2'b11;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [1:0] a, a1;
   logic [1:0] raw0, out0, rise0, fall0;
   logic [1:0] raw1, out1, rise1, fall1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sync_filter #(.WIDTH(2), .STAGES(2), .FILT_CYC(3), .RST_VAL(2'b11)) dut (
      .clk(clk), .n_rst(n_rst), .async_in(a),
      .sync_raw(raw0), .sync_out(out0), .rise(rise0), .fall(fall0));

   sync_filter #(.WIDTH(2), .STAGES(2), .FILT_CYC(1), .RST_VAL(2'b11)) dut1 (
      .clk(clk), .n_rst(n_rst), .async_in(a1),
      .sync_raw(raw1), .sync_out(out1), .rise(rise1), .fall(fall1));

   // Reference model, one entry per instance.
   // m_in[i][k]: input sampled k edges ago (k=0 is this edge).
   // m_rh[i][k]: synchronized raw level k cycles ago (k=0 is current).
   logic [1:0] m_in  [2][STG];
   logic [1:0] m_rh  [2][3];
   logic [1:0] m_raw [2];
   logic [1:0] m_out [2];
   logic [1:0] m_rise[2];
   logic [1:0] m_fall[2];

   task automatic model_step(input int inst, input int f, input logic rstn,
                             input logic [1:0] din);
      logic [1:0] commit;
      bit         all_diff;
      if (!rstn) begin
         for (int k = 0; k < STG; k++) m_in[inst][k] = RV;
         for (int k = 0; k < 3; k++)   m_rh[inst][k] = RV;
         m_raw[inst]  = RV;
         m_out[inst]  = RV;
         m_rise[inst] = 2'b00;
         m_fall[inst] = 2'b00;
      end else begin
         // A level is accepted once the raw level has disagreed with the
         // filtered level for the last f cycles.
         commit = 2'b00;
         for (int c = 0; c < 2; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < f; k++)
               if (m_rh[inst][k][c] == m_out[inst][c]) all_diff = 1'b0;
            commit[c] = all_diff;
         end
         m_rise[inst] = commit & ~m_out[inst];
         m_fall[inst] = commit & m_out[inst];
         m_out[inst]  = m_out[inst] ^ commit;
         for (int k = STG - 1; k > 0; k--) m_in[inst][k] = m_in[inst][k-1];
         m_in[inst][0] = din;
         m_raw[inst]   = m_in[inst][STG-1];
         for (int k = 2; k > 0; k--) m_rh[inst][k] = m_rh[inst][k-1];
         m_rh[inst][0] = m_raw[inst];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, 3, n_rst, a);
      model_step(1, 1, n_rst, a1);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; a = 2'b00; a1 = 2'b00;
      for (int j = 0; j < 4; j++) begin
         if (j == 3) n_rst = 1'b1;
         tick();
         total++;
         if ({raw0, out0, rise0, fall0} !== {RV, RV, 4'b0000}) begin
            bad++;
            $display("FAIL reset_dut j=%0d: got raw=%b out=%b rise=%b fall=%b want raw=11 out=11 rise=00 fall=00",
                     j, raw0, out0, rise0, fall0);
         end
         total++;
         if ({raw1, out1, rise1, fall1} !== {RV, RV, 4'b0000}) begin
            bad++;
            $display("FAIL reset_dut1 j=%0d: got raw=%b out=%b rise=%b fall=%b want raw=11 out=11 rise=00 fall=00",
                     j, raw1, out1, rise1, fall1);
         end
      end
   endtask

   task automatic test_clean_fall();
      a = 2'b11;
      repeat (8) tick();
      a = 2'b10;
      for (int j = 1; j <= 7; j++) begin
         tick();
         total++;
         if (raw0 !== {1'b1, (j >= 2) ? 1'b0 : 1'b1}) begin
            bad++;
            $display("FAIL clean_fall_raw j=%0d: got %b want %b", j, raw0,
                     {1'b1, (j >= 2) ? 1'b0 : 1'b1});
         end
         total++;
         if (out0 !== {1'b1, (j >= 5) ? 1'b0 : 1'b1}) begin
            bad++;
            $display("FAIL clean_fall_out j=%0d: got %b want %b", j, out0,
                     {1'b1, (j >= 5) ? 1'b0 : 1'b1});
         end
         total++;
         if ({rise0, fall0} !== {2'b00, 1'b0, (j == 5)}) begin
            bad++;
            $display("FAIL clean_fall_pulse j=%0d: got rise=%b fall=%b want rise=00 fall=0%b",
                     j, rise0, fall0, (j == 5));
         end
      end
   endtask

   task automatic test_glitch();
      int lowcnt;
      lowcnt = 0;
      // Two 2-cycle glitches one cycle apart: a stale count would commit.
      for (int j = 1; j <= 12; j++) begin
         a = (j == 1 || j == 2 || j == 4 || j == 5) ? 2'b00 : 2'b10;
         tick();
         if (raw0[1] === 1'b0) lowcnt++;
         total++;
         if (out0[1] !== 1'b1 || fall0[1] !== 1'b0 || rise0[1] !== 1'b0) begin
            bad++;
            $display("FAIL glitch j=%0d: got out1=%b fall1=%b rise1=%b want out1=1 fall1=0 rise1=0",
                     j, out0[1], fall0[1], rise0[1]);
         end
      end
      total++;
      if (lowcnt != 4) begin
         bad++;
         $display("FAIL glitch_raw_low: got %0d cycles want 4", lowcnt);
      end
   endtask

   task automatic test_reset_release();
      n_rst = 1'b0; a = 2'b00;
      for (int j = 0; j < 2; j++) begin
         tick();
         total++;
         if ({out0, rise0, fall0} !== {RV, 4'b0000}) begin
            bad++;
            $display("FAIL rst_entry j=%0d: got out=%b rise=%b fall=%b want out=11 rise=00 fall=00",
                     j, out0, rise0, fall0);
         end
      end
      n_rst = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         tick();
         total++;
         if (out0 !== ((j >= 5) ? 2'b00 : 2'b11)) begin
            bad++;
            $display("FAIL rst_release_out j=%0d: got %b want %b", j, out0,
                     (j >= 5) ? 2'b00 : 2'b11);
         end
         total++;
         if ({rise0, fall0} !== {2'b00, (j == 5) ? 2'b11 : 2'b00}) begin
            bad++;
            $display("FAIL rst_release_pulse j=%0d: got rise=%b fall=%b", j, rise0, fall0);
         end
      end
   endtask

   task automatic test_mid_reset();
      a = 2'b11;
      repeat (8) tick();
      a = 2'b10;
      repeat (4) tick();
      total++;
      if (out0 !== 2'b11) begin
         bad++;
         $display("FAIL mid_pending_out: got %b want 11", out0);
      end
      n_rst = 1'b0;
      tick();
      total++;
      if ({out0, rise0, fall0} !== {RV, 4'b0000}) begin
         bad++;
         $display("FAIL mid_reset: got out=%b rise=%b fall=%b want out=11 rise=00 fall=00",
                  out0, rise0, fall0);
      end
      n_rst = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         tick();
         total++;
         if (out0 !== {1'b1, (j >= 5) ? 1'b0 : 1'b1} || fall0 !== {1'b0, (j == 5)}) begin
            bad++;
            $display("FAIL mid_relatency j=%0d: got out=%b fall=%b want out=%b fall=0%b",
                     j, out0, fall0, {1'b1, (j >= 5) ? 1'b0 : 1'b1}, (j == 5));
         end
      end
   endtask

   task automatic test_filt1();
      a1 = 2'b10;
      repeat (6) tick();
      a1 = 2'b01;
      for (int j = 1; j <= 4; j++) begin
         tick();
         total++;
         if (raw1 !== ((j >= 2) ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL filt1_raw j=%0d: got %b want %b", j, raw1, (j >= 2) ? 2'b01 : 2'b10);
         end
         total++;
         if (out1 !== ((j >= 3) ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL filt1_out j=%0d: got %b want %b", j, out1, (j >= 3) ? 2'b01 : 2'b10);
         end
         total++;
         if ({rise1, fall1} !== ((j == 3) ? 4'b0110 : 4'b0000)) begin
            bad++;
            $display("FAIL filt1_pulse j=%0d: got rise=%b fall=%b", j, rise1, fall1);
         end
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 800; j++) begin
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 5) == 0) a[c]  = ~a[c];
            if ($urandom_range(0, 3) == 0) a1[c] = ~a1[c];
         end
         n_rst = ($urandom_range(0, 99) != 0);
         tick();
         total++;
         if ({raw0, out0, rise0, fall0} !== {m_raw[0], m_out[0], m_rise[0], m_fall[0]}) begin
            bad++;
            $display("FAIL rand_f3 j=%0d: got raw=%b out=%b rise=%b fall=%b want raw=%b out=%b rise=%b fall=%b",
                     j, raw0, out0, rise0, fall0, m_raw[0], m_out[0], m_rise[0], m_fall[0]);
         end
         total++;
         if ({raw1, out1, rise1, fall1} !== {m_raw[1], m_out[1], m_rise[1], m_fall[1]}) begin
            bad++;
            $display("FAIL rand_f1 j=%0d: got raw=%b out=%b rise=%b fall=%b want raw=%b out=%b rise=%b fall=%b",
                     j, raw1, out1, rise1, fall1, m_raw[1], m_out[1], m_rise[1], m_fall[1]);
         end
         total++;
         if (((rise0 & fall0) | (rise1 & fall1)) !== 2'b00) begin
            bad++;
            $display("FAIL rand_both_pulses j=%0d: got %b/%b want 00", j, rise0 & fall0, rise1 & fall1);
         end
      end
   endtask

   initial begin
      n_rst = 1'b0;
      a     = 2'b00;
      a1    = 2'b00;
      test_reset();
      test_clean_fall();
      test_glitch();
      test_reset_release();
      test_mid_reset();
      test_filt1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Parametrised multi-channel input conditioner for asynchronous pins such as USB D+/D- and external strobes.
- Each channel has an N-stage synchronizer with a per-bit reset value, followed by a stability (glitch) filter.
- Each channel emits registered single-cycle rise/fall pulses.
- Sits at the chip boundary, ahead of the USB receiver and edge-detect/decode logic.

Parameters:
WIDTH, 2, number of independent channels (>=1)
STAGES, 2, synchronizer flop depth (>=2; elaboration-time assertion on violation)
RST_VAL, {WIDTH{1'b1}}, per-channel reset/idle level for every sync stage and sync_out
FILT_CYC, 3, consecutive cycles sync_raw must differ from sync_out before sync_out updates (>=1)

Ports:
clk  input  1  system clock
n_rst  input  1  reset, synchronous, active-low
async_in  input  WIDTH  asynchronous inputs, one per channel
sync_raw  output  WIDTH  last synchronizer stage, unfiltered
sync_out  output  WIDTH  filtered, synchronized level
rise  output  WIDTH  one-cycle pulse when sync_out[i] goes 0->1
fall  output  WIDTH  one-cycle pulse when sync_out[i] goes 1->0

Behaviour:
- Clock/reset: one clock domain. Reset is synchronous: it is sampled only at posedge clk with n_rst==0.
- Reset values:
  - All sync stages = RST_VAL; sync_raw = RST_VAL; sync_out = RST_VAL.
  - Filter counters = 0; rise = fall = 0.
- Synchronizer: stage0 <= async_in, stage k <= stage k-1, sync_raw = stage STAGES-1.
  - A change on async_in appears on sync_raw after exactly STAGES edges.
- Filter, per channel i, with counter cnt[i] of width $clog2(FILT_CYC+1):
  - sync_raw[i]==sync_out[i]: cnt <= 0, no change.
  - mismatch and cnt < FILT_CYC-1: cnt <= cnt+1.
  - mismatch and cnt == FILT_CYC-1: commit. sync_out[i] <= sync_raw[i], cnt <= 0.
  - Net: sync_out updates at the FILT_CYC-th consecutive mismatch edge.
  - End-to-end latency async_in -> sync_out = STAGES+FILT_CYC edges.
- Glitches: a sync_raw excursion shorter than FILT_CYC cycles clears cnt on return. sync_out does not change and no pulse is produced.
- Edge pulses are registered and asserted in the same cycle the new sync_out value is visible:
  - rise[i] <= commit & sync_raw[i]; fall[i] <= commit & ~sync_raw[i].
  - Each pulse lasts exactly one cycle.
  - rise and fall are never both high on one channel.
- Channels are fully independent. Simultaneous transitions on different channels are filtered and pulsed independently.
- Reset mid-operation: pending counts are discarded and outputs return to RST_VAL. No pulse is generated by reset entry.
- Reset release: if async_in differs from RST_VAL, the normal filtered transition and pulse occur STAGES+FILT_CYC edges after the first non-reset edge.
- FILT_CYC==1: sync_out is sync_raw delayed one cycle. Pulses still fire on every change.
- No combinational path from async_in to any output. Every output is a flop.

Decomposition:
- Package sync_pkg holds:
  - function cnt_width(filt_cyc) returning $clog2(filt_cyc+1);
  - default constants SYNC_STAGES_DEF=2 and FILT_CYC_DEF=3;
  - typedef edge_t, a struct {rise, fall} for consumers.
- Sub-module sync_filter_chan is the 1-bit channel: sync chain + counter + edge regs, with a scalar RST_VAL bit.
- The top instantiates WIDTH copies in a generate loop, passing RST_VAL[i].

Test Plan (WIDTH=2, STAGES=2, FILT_CYC=3, RST_VAL=2'b11 unless noted):
1. Reset: n_rst=0 for 3 edges with async_in=2'b00 -> sync_raw=2'b11, sync_out=2'b11, rise=fall=2'b00 during reset and on the first edge after release.
2. Clean fall: from steady 2'b11, drive async_in[0]=0 just after edge k and hold -> sync_raw[0]=0 from edge k+2, sync_out[0]=0 and fall[0]=1 at edge k+5 only, fall[0]=0 at k+6; channel 1 static, no pulses.
3. Glitch reject: async_in[1] low for 2 cycles then high -> sync_raw[1] low 2 cycles; sync_out[1] stays 1; fall[1] never asserts; cnt returns to 0.
4. Reset release mismatch: release n_rst with async_in=2'b00 -> sync_out goes 2'b11->2'b00 at the 5th edge after release, fall=2'b11 for that one cycle, rise=2'b00.
5. Mid-filter reset: with ch0 at cnt=2 (mismatch pending), assert n_rst for 1 edge -> cnt=0, sync_out=2'b11, no pulse. After release, the full 5-edge latency applies again.
6. Independence and FILT_CYC=1: rebuild with FILT_CYC=1; toggle ch0 0->1 and ch1 1->0 on the same edge -> both sync_out bits update at edge+3; rise=2'b01 and fall=2'b10 for one cycle.
